// File: rtl/czono_linear_image_seq_pkg.sv
// Shared types and helpers for the constrained-zonotope linear image block:
// FSM encoding, IEEE-754 constants and flattened-array offset helpers.
package czono_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Bit offset of element [row][col] in a row-major flattened matrix.
  function automatic int mat_idx(input int row, input int col, input int ncols, input int dw);
    return (row * ncols + col) * dw;
  endfunction

  function automatic logic dim_bad(input int v, input int vmax);
    return (v == 0) || (v > vmax);
  endfunction

endpackage

// File: rtl/czono_linear_image_seq_if.sv
// Operand, control and result bundle between the operand store and the linear image engine.
interface czono_linear_image_seq_if #(
  parameter int NMAX  = 3,
  parameter int NGMAX = 15,
  parameter int NCMAX = 12,
  parameter int NRMAX = 3,
  parameter int DW    = 32
);
  localparam int NW = $clog2(NMAX + 1);
  localparam int RW = $clog2(NRMAX + 1);
  localparam int GW = $clog2(NGMAX + 1);
  localparam int CW = $clog2(NCMAX + 1);

  logic                          start_i;
  logic                          busy_o;
  logic                          done_o;
  logic                          error_o;
  logic [NW-1:0]                 z_n_i;
  logic [NW-1:0]                 r_n_i;
  logic [RW-1:0]                 r_nr_i;
  logic [GW-1:0]                 z_ng_i;
  logic [CW-1:0]                 z_nc_i;
  logic [NRMAX*NMAX*DW-1:0]      r_mat_i;
  logic [NMAX*DW-1:0]            z_c_i;
  logic [NMAX*NGMAX*DW-1:0]      z_g_i;
  logic [NCMAX*NGMAX*DW-1:0]     z_a_i;
  logic [NCMAX*DW-1:0]           z_b_i;
  logic [RW-1:0]                 out_n_o;
  logic [GW-1:0]                 out_ng_o;
  logic [CW-1:0]                 out_nc_o;
  logic [NRMAX*DW-1:0]           out_c_o;
  logic [NRMAX*NGMAX*DW-1:0]     out_g_o;
  logic [NCMAX*NGMAX*DW-1:0]     out_a_o;
  logic [NCMAX*DW-1:0]           out_b_o;

  modport master (
    output start_i, z_n_i, r_n_i, r_nr_i, z_ng_i, z_nc_i,
           r_mat_i, z_c_i, z_g_i, z_a_i, z_b_i,
    input  busy_o, done_o, error_o, out_n_o, out_ng_o, out_nc_o,
           out_c_o, out_g_o, out_a_o, out_b_o
  );

  modport slave (
    input  start_i, z_n_i, r_n_i, r_nr_i, z_ng_i, z_nc_i,
           r_mat_i, z_c_i, z_g_i, z_a_i, z_b_i,
    output busy_o, done_o, error_o, out_n_o, out_ng_o, out_nc_o,
           out_c_o, out_g_o, out_a_o, out_b_o
  );
endinterface

// File: rtl/czono_linear_image_seq_fp_mac.sv
// One MAC lane: sum = (first ? 0 : acc) + a*b in IEEE single, round-to-nearest-even.
// Like the 8/23 internal float format, subnormal operands and results flush to signed zero.
module czono_fp_mac
  import czono_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] acc_i,
  input  logic                  first_i,
  output logic [DATA_WIDTH-1:0] sum_o
);

  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic        s, g, st;
    logic [47:0] p;
    logic [23:0] m;
    int          e;
    s = x[31] ^ y[31];
    if ((x[30:23] == 8'hFF && x[22:0] != 0) || (y[30:23] == 8'hFF && y[22:0] != 0) ||
        (x[30:23] == 8'hFF && y[30:23] == 8'h00) || (y[30:23] == 8'hFF && x[30:23] == 8'h00))
      return FP_QNAN;
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) return {s, 8'hFF, 23'h0};
    if (x[30:23] == 8'h00 || y[30:23] == 8'h00) return {s, 31'h0};
    p = {24'h0, 1'b1, x[22:0]} * {24'h0, 1'b1, y[22:0]};
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (p[47]) begin
      m  = {1'b0, p[46:24]};
      g  = p[23];
      st = |p[22:0];
      e  = e + 1;
    end else begin
      m  = {1'b0, p[45:23]};
      g  = p[22];
      st = |p[21:0];
    end
    if (g && (st || m[0])) m = m + 24'd1;
    if (m[23]) begin
      m = 24'd0;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] big, sml;
    logic [27:0] mb, ms_full, ms, sum;
    logic [23:0] m;
    logic        g, st, x_inf, y_inf;
    int          d, e;
    x_inf = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    y_inf = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    if ((x[30:23] == 8'hFF && x[22:0] != 0) || (y[30:23] == 8'hFF && y[22:0] != 0) ||
        (x_inf && y_inf && x[31] != y[31]))
      return FP_QNAN;
    if (x_inf) return x;
    if (y_inf) return y;
    if (x[30:23] == 8'h00 && y[30:23] == 8'h00) return {x[31] & y[31], 31'h0};
    if (x[30:23] == 8'h00) return y;
    if (y[30:23] == 8'h00) return x;
    if (x[30:0] >= y[30:0]) begin
      big = x;
      sml = y;
    end else begin
      big = y;
      sml = x;
    end
    d       = int'(big[30:23]) - int'(sml[30:23]);
    e       = int'(big[30:23]);
    mb      = {2'b01, big[22:0], 3'b000};
    ms_full = {2'b01, sml[22:0], 3'b000};
    // Bits shifted out of the smaller operand collapse into the sticky LSB.
    if (d > 27) begin
      ms = 28'd1;
    end else begin
      ms    = ms_full >> d;
      ms[0] = ms[0] | (|(ms_full & ((28'd1 << d) - 28'd1)));
    end
    sum = (big[31] == sml[31]) ? (mb + ms) : (mb - ms);
    if (sum == 28'd0) return FP_ZERO;
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e   = e + 1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!sum[26]) begin
          sum = sum << 1;
          e   = e - 1;
        end
      end
    end
    m  = {1'b0, sum[25:3]};
    g  = sum[2];
    st = sum[1] | sum[0];
    if (g && (st || m[0])) m = m + 24'd1;
    if (m[23]) begin
      m = 24'd0;
      e = e + 1;
    end
    if (e >= 255) return {big[31], 8'hFF, 23'h0};
    if (e <= 0) return {big[31], 31'h0};
    return {big[31], e[7:0], m[22:0]};
  endfunction

  logic [DATA_WIDTH-1:0] prod;

  assign prod  = fp_mul(a_i, b_i);
  assign sum_o = first_i ? prod : fp_add(acc_i, prod);

endmodule

// File: rtl/czono_linear_image_seq.sv
// Sequential linear image of a constrained zonotope: out = {R*c, R*G, A, b},
// computed row by row over blocks of NLANES extended columns (c, then G columns).
module czono_linear_image_seq
  import czono_pkg::*;
#(
  parameter int NMAX   = 3,
  parameter int NGMAX  = 15,
  parameter int NCMAX  = 12,
  parameter int NRMAX  = 3,
  parameter int NLANES = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  czono_linear_image_seq_if.slave  bus
);
  localparam int DW = DATA_WIDTH;
  localparam int NW = $clog2(NMAX + 1);
  localparam int RW = $clog2(NRMAX + 1);
  localparam int GW = $clog2(NGMAX + 1);
  localparam int CW = $clog2(NCMAX + 1);
  localparam int BW = $clog2((NGMAX + NLANES) / NLANES + 1);

  state_e                     state_q, state_d;
  logic [NW-1:0]              n_q, n_d, rn_q, rn_d, k_q, k_d;
  logic [RW-1:0]              nr_q, nr_d, row_q, row_d;
  logic [GW-1:0]              ng_q, ng_d;
  logic [CW-1:0]              nc_q, nc_d;
  logic [BW-1:0]              nblk_q, nblk_d, blk_q, blk_d;
  logic [DW-1:0]              acc_q [NLANES];
  logic [DW-1:0]              acc_d [NLANES];
  logic [RW-1:0]              out_n_q, out_n_d;
  logic [GW-1:0]              out_ng_q, out_ng_d;
  logic [CW-1:0]              out_nc_q, out_nc_d;
  logic [NRMAX*DW-1:0]        out_c_q, out_c_d;
  logic [NRMAX*NGMAX*DW-1:0]  out_g_q, out_g_d;
  logic [NCMAX*NGMAX*DW-1:0]  out_a_q, out_a_d;
  logic [NCMAX*DW-1:0]        out_b_q, out_b_d;
  logic                       err_q, err_d;

  logic                       accept, fault, last_k, last_blk, last_row, first;
  logic [DW-1:0]              mac_a;
  logic [DW-1:0]              mac_x   [NLANES];
  logic [DW-1:0]              mac_sum [NLANES];
  int                         lane_col [NLANES];
  logic                       lane_act [NLANES];

  assign accept   = bus.start_i && (state_q == ST_IDLE || state_q == ST_DONE);
  assign fault    = (n_q != rn_q) || dim_bad(int'(n_q), NMAX) || dim_bad(int'(nr_q), NRMAX) ||
                    dim_bad(int'(ng_q), NGMAX) || (int'(nc_q) > NCMAX);
  assign last_k   = (k_q == n_q - NW'(1));
  assign last_blk = (blk_q == nblk_q - BW'(1));
  assign last_row = (row_q == nr_q - RW'(1));
  assign first    = (k_q == '0);
  assign mac_a    = bus.r_mat_i[mat_idx(int'(row_q), int'(k_q), NMAX, DW) +: DW];

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    assign lane_col[l] = int'(blk_q) * NLANES + l;
    assign lane_act[l] = (lane_col[l] <= int'(ng_q));
    czono_fp_mac u_mac (
      .a_i     (mac_a),
      .b_i     (mac_x[l]),
      .acc_i   (acc_q[l]),
      .first_i (first),
      .sum_o   (mac_sum[l])
    );
  end

  // Column 0 of the extended operand is c; column j+1 is G[.][j].
  always_comb begin
    for (int l = 0; l < NLANES; l++) begin
      mac_x[l] = FP_ZERO;
      if (lane_act[l]) begin
        if (lane_col[l] == 0) mac_x[l] = bus.z_c_i[int'(k_q)*DW +: DW];
        else mac_x[l] = bus.z_g_i[mat_idx(int'(k_q), lane_col[l] - 1, NGMAX, DW) +: DW];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_CHECK;
      ST_CHECK:   state_d = fault ? ST_DONE : ST_COMPUTE;
      ST_COMPUTE: if (last_k && last_blk && last_row) state_d = ST_DONE;
      ST_DONE:    state_d = accept ? ST_CHECK : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy_o = (state_q == ST_CHECK) || (state_q == ST_COMPUTE);
    bus.done_o = (state_q == ST_DONE);
  end

  always_comb begin
    n_d = n_q;  rn_d = rn_q;  nr_d = nr_q;  ng_d = ng_q;  nc_d = nc_q;
    k_d = k_q;  row_d = row_q;  blk_d = blk_q;  nblk_d = nblk_q;
    for (int l = 0; l < NLANES; l++) acc_d[l] = acc_q[l];
    out_n_d = out_n_q;  out_ng_d = out_ng_q;  out_nc_d = out_nc_q;
    out_c_d = out_c_q;  out_g_d = out_g_q;  out_a_d = out_a_q;  out_b_d = out_b_q;
    err_d   = err_q;

    if (accept) begin
      n_d   = bus.z_n_i;
      rn_d  = bus.r_n_i;
      nr_d  = bus.r_nr_i;
      ng_d  = bus.z_ng_i;
      nc_d  = bus.z_nc_i;
      err_d = 1'b0;
    end

    if (state_q == ST_CHECK) begin
      err_d = fault;
      if (!fault) begin
        nblk_d = BW'((int'(ng_q) + NLANES) / NLANES);
        row_d  = '0;
        blk_d  = '0;
        k_d    = '0;
        out_c_d = '0;
        out_g_d = '0;
        out_a_d = '0;
        out_b_d = '0;
        for (int i = 0; i < NCMAX; i++) begin
          if (i < int'(nc_q)) begin
            out_b_d[i*DW +: DW] = bus.z_b_i[i*DW +: DW];
            for (int j = 0; j < NGMAX; j++) begin
              if (j < int'(ng_q))
                out_a_d[mat_idx(i, j, NGMAX, DW) +: DW] = bus.z_a_i[mat_idx(i, j, NGMAX, DW) +: DW];
            end
          end
        end
        out_n_d  = nr_q;
        out_ng_d = ng_q;
        out_nc_d = nc_q;
      end
    end

    if (state_q == ST_COMPUTE) begin
      for (int l = 0; l < NLANES; l++) begin
        acc_d[l] = mac_sum[l];
        if (last_k && lane_act[l]) begin
          if (lane_col[l] == 0) out_c_d[int'(row_q)*DW +: DW] = mac_sum[l];
          else out_g_d[mat_idx(int'(row_q), lane_col[l] - 1, NGMAX, DW) +: DW] = mac_sum[l];
        end
      end
      if (!last_k) begin
        k_d = k_q + NW'(1);
      end else begin
        k_d = '0;
        if (!last_blk) begin
          blk_d = blk_q + BW'(1);
        end else begin
          blk_d = '0;
          row_d = last_row ? '0 : row_q + RW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      n_q <= '0;  rn_q <= '0;  nr_q <= '0;  ng_q <= '0;  nc_q <= '0;
      k_q <= '0;  row_q <= '0;  blk_q <= '0;  nblk_q <= '0;
      for (int l = 0; l < NLANES; l++) acc_q[l] <= '0;
      out_n_q <= '0;  out_ng_q <= '0;  out_nc_q <= '0;
      out_c_q <= '0;  out_g_q <= '0;  out_a_q <= '0;  out_b_q <= '0;
      err_q   <= 1'b0;
    end else begin
      n_q <= n_d;  rn_q <= rn_d;  nr_q <= nr_d;  ng_q <= ng_d;  nc_q <= nc_d;
      k_q <= k_d;  row_q <= row_d;  blk_q <= blk_d;  nblk_q <= nblk_d;
      for (int l = 0; l < NLANES; l++) acc_q[l] <= acc_d[l];
      out_n_q <= out_n_d;  out_ng_q <= out_ng_d;  out_nc_q <= out_nc_d;
      out_c_q <= out_c_d;  out_g_q <= out_g_d;  out_a_q <= out_a_d;  out_b_q <= out_b_d;
      err_q   <= err_d;
    end
  end

  assign bus.error_o  = err_q;
  assign bus.out_n_o  = out_n_q;
  assign bus.out_ng_o = out_ng_q;
  assign bus.out_nc_o = out_nc_q;
  assign bus.out_c_o  = out_c_q;
  assign bus.out_g_o  = out_g_q;
  assign bus.out_a_o  = out_a_q;
  assign bus.out_b_o  = out_b_q;

endmodule

// File: doc/czono_linear_image_seq.md
Name: czono_linear_image_seq

Overview:
- Sequential, handshaked computation of the linear image of a constrained zonotope: OUT = {R·c, R·G, A, b}.
- Single-precision IEEE-754 multiply-accumulate over NLANES parallel column lanes.
- Registered outputs, start/done handshake and dimension checking.
- Sits between the CZonotope operand store and downstream set operations (Minkowski sum, intersection).

Parameters:
- NMAX, 3, max state dimension n
- NGMAX, 15, max generator count ng
- NCMAX, 12, max constraint count nc
- NRMAX, 3, max rows nr of R
- DATA_WIDTH, 32, IEEE-754 word width (single only)
- NLANES, 4, parallel MAC lanes (1..NGMAX+1)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  async active-low reset
- start_i  in  1  request; accepted only in IDLE or DONE
- busy_o  out  1  high from accepted start until done_o
- done_o  out  1  one-cycle completion pulse
- error_o  out  1  with done_o: dimension fault; cleared on next accepted start
- z_n_i, r_n_i  in  $clog2(NMAX+1)  Z and R column dimensions
- r_nr_i  in  $clog2(NRMAX+1)  rows of R
- z_ng_i  in  $clog2(NGMAX+1)  generators
- z_nc_i  in  $clog2(NCMAX+1)  constraints
- r_mat_i  in  NRMAX*NMAX*DATA_WIDTH  R[r][k] at [(r*NMAX+k)*DW +: DW]
- z_c_i  in  NMAX*DW  c[k]
- z_g_i  in  NMAX*NGMAX*DW  G[k][j] at [(k*NGMAX+j)*DW +: DW]
- z_a_i  in  NCMAX*NGMAX*DW  A[i][j]
- z_b_i  in  NCMAX*DW  b[i]
- out_n_o, out_ng_o, out_nc_o  out  as inputs  result dimensions
- out_c_o, out_g_o, out_a_o, out_b_o  out  NRMAX*DW, NRMAX*NGMAX*DW, as A, as b  result data

Behaviour:
- Reset: all outputs 0; FSM IDLE; counters and accumulators 0.
- Dimensions are latched on the accepted start. Data inputs must be held stable while busy_o is high.
- FSM states: IDLE, CHECK, COMPUTE, DONE.
  - IDLE/DONE --start_i--> CHECK. start_i in CHECK or COMPUTE is ignored.
  - CHECK (1 cycle): fault if z_n≠r_n, or any of n, nr, ng is 0, or any dimension exceeds its MAX.
    - On fault: go to DONE with error_o=1; output registers are unchanged.
    - Otherwise: clear out_c/out_g/out_a/out_b to 0, copy A[i][j] for i<nc, j<ng and b[i] for i<nc, and set out_n=nr, out_ng=ng, out_nc=nc.
  - COMPUTE: work over the extended column set. Column 0 is c; column j+1 is G[·][j]. There are ng+1 columns in ceil((ng+1)/NLANES) blocks.
    - Loop order: row r outer, block middle, k inner (0..n-1).
    - Each lane computes acc ← (k==0 ? 0 : acc) + R[r][k]·X[k][col]. The k==0 step loads the product directly, so there are no −0 artefacts.
    - At k==n-1 each active lane writes its result to out_c[r] (col 0) or out_g[r][col-1]. Lanes with col>ng are idle and write nothing.
    - After the last r, block and k: go to DONE.
  - DONE: done_o=1 for exactly 1 cycle, busy_o=0. Then IDLE, unless start_i is high in the DONE cycle, which goes directly to CHECK.
- Latency from start to done_o: 2 + nr·ceil((ng+1)/NLANES)·n cycles (start edge, CHECK, COMPUTE). A fault gives done_o 2 cycles after start.
- Arithmetic: each lane is one combinational FP multiply and one FP add per cycle, using the team's FloPoCo IEEE 8/23 conversion, mult and add cores. Rounding is round-to-nearest-even. NaN/Inf propagate; no flags.
- Reset mid-operation: immediately IDLE, all outputs 0, no done_o.
- busy_o is high from the cycle after the accepted start through the last COMPUTE cycle.

Decomposition:
- Package czono_pkg:
  - DATA_WIDTH default and IEEE constants (FP_ZERO=32'h0, FP_ONE=32'h3F800000)
  - FSM state enum
  - index helper functions for the flattened-array offsets
- Sub-module czono_fp_mac: ieee_in/mult/add/ieee_out wrapper; inputs a, b, acc, first; output sum. Instantiated NLANES times.

Test Plan:
- Scaling: R=[[2,0],[0,3]] (0x40000000, 0x40400000), c=[1,1], G=[[1,0.5],[0,1]], NLANES=4.
  -> out_c=[0x40000000, 0x40400000], out_g=[[0x40000000, 0x3F800000], [0, 0x40400000]], done_o 6 cycles after start, error_o=0.
- Same operands with NLANES=1 -> identical results, done_o at 2+2·3·2=14 cycles.
- Lane leftover: n=3, nr=3, ng=4, NLANES=4, R=I3, G all 1.0.
  -> out_g equals G, out_g[r][j≥4]=0, latency 2+3·2·3=20.
- Mismatch: z_n=3, r_n=2 -> done_o with error_o=1 at cycle 2, outputs keep the previous result; a following valid start clears error_o.
- Ignored start: assert start_i again mid-COMPUTE -> one done_o only, latency unchanged. Back-to-back: start_i held high in the DONE cycle -> next CHECK follows immediately.
- Reset mid-COMPUTE: drop rstn_i -> all outputs 0 asynchronously, busy_o=0, no done_o; a fresh start then completes normally.
